thor2022_hpt_inserter: RTL
==========================

Name: thor2022_hpt_inserter

Overview:
- Hash-page-table insert engine: the write side of the hash page table that the MMU's table walker reads.
- Accepts one 128-bit HPTE from the TLB-miss/OS-assist path and hashes {asid,vpn} to a page-table group (PTG) of 8 HPTEs.
- Scans the PTG over the memory bus and writes the entry into one slot: the matching slot, else the first free slot, else a clock-selected victim.
- Sits beside the table walker on the MMU memory-arbiter port.

Parameters:
AWID, 32, physical address width
PTE_PER_PTG, 8, HPTEs per PTG; power of two
HASH_BITS, 10, PTG index width (1024 PTGs)
PTG_BYTES, 128, bytes per PTG (PTE_PER_PTG x 16)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
req_i  in  1  insert request; sampled when req_ready_o=1
req_ready_o  out  1  engine idle, may accept req_i
hpte_i  in  128  HPTE to insert; HPTE field layout from the MMU package
hpt_base_i  in  AWID  HPT base address; 128-byte aligned
done_o  out  1  one-cycle completion pulse
slot_o  out  3  slot written; valid with done_o
evict_o  out  1  with done_o: a valid non-matching entry was overwritten
err_o  out  1  with done_o: bus error, nothing written
m_cyc_o  out  1  bus cycle active
m_we_o  out  1  write strobe
m_adr_o  out  AWID  byte address, 16-byte aligned
m_dat_o  out  128  write data
m_dat_i  in  128  read data
m_ack_i  in  1  transfer acknowledge
m_err_i  in  1  transfer error; terminates the beat like ack

Behaviour:
- Reset value of all outputs is 0, except req_ready_o=1.
- Reset also clears the clock pointer to 0.
- Reset mid-transaction drops m_cyc_o immediately; no done_o is produced.
- Request capture: on req_i & req_ready_o, latch hpte_i into ent and hpt_base_i into base; req_ready_o falls the next cycle.
- PTG index: idx = ent.vpn[9:0] ^ ent.asid.
- PTG address: ptg = base + idx*PTG_BYTES.
- Slot address: ptg + k*16, computed modulo 2^AWID.
- State IDLE: go to RD with k=0 on an accepted request.
- State RD: m_cyc_o=1, m_we_o=0, address = slot k. m_cyc_o stays high until ack or err.
- On m_err_i in RD or WR: go to FIN with err_o=1.
- On m_ack_i in RD, classify m_dat_i:
  - match = v & asid==ent.asid & vpn==ent.vpn & vpnhi==ent.vpnhi. Record k and go to WR immediately (early exit).
  - free = !v. On the first free slot only, record k as free_slot.
  - Then k+1: if k=7, go to SEL; else stay in RD.
- State SEL: target = free_slot if one was found, else clk_ptr. In the victim case set evict_o and advance clk_ptr by 1 (wraps 7->0).
- State WR: m_cyc_o=1, m_we_o=1, m_dat_o = ent with v forced to 1. Go to FIN on ack.
- State FIN: done_o=1 for exactly one cycle, with slot_o/evict_o/err_o. Then go to IDLE and raise req_ready_o.
- A match takes priority over any free slot seen earlier in the scan.
- The match case never sets evict_o and never advances clk_ptr.
- Latency with zero-wait bus, cycles from accept to done_o:
  - match in slot j: j+3
  - no match: 11 (8 reads, SEL, WR, FIN)
- Bus stall: m_cyc_o, m_we_o, m_adr_o and m_dat_o stay stable while ack and err are both low.
- m_ack_i or m_err_i arriving while m_cyc_o=0 is ignored.
- req_i while busy is ignored; it is not queued.

Decomposition:
- Add to the MMU package:
  - HPTE_BYTES=16
  - enum for IDLE/RD/SEL/WR/FIN, in the style of the IPT_* state constants
  - a function hpt_hash(asid,vpn) returning the PTG index; the table walker reuses it so both sides hash identically
- One sub-module, thor2022_hpt_slot_sel: combinational match/free classifier plus the registered first-free tracker. Keeps the FSM body small.

Test Plan:
- Empty PTG (all v=0), base=0x10000, asid=0x005, vpn=0x0003:
  - idx=0x006, so slot 0 is read at 0x10300 and written at 0x10300
  - slot_o=0, evict_o=0, done_o at cycle 11
- Slot 2 holds the same asid/vpn/vpnhi: reads stop after slot 2, write goes to ptg+0x20, slot_o=2, evict_o=0, done_o at cycle 5.
- Slots 0-4 valid non-matching, 5-7 free: all 8 slots are read, then slot 5 is written.
- Full PTG, no match, three successive inserts: slots 0, 1, 2 are written with evict_o=1 each time. A reset afterwards, then another insert, writes slot 0 again.
- m_err_i on the read of slot 3: done_o with err_o=1, no write cycle issued, clk_ptr unchanged.
- Random ack delays of 0-5 cycles, with rst_ni pulsed low mid-WR:
  - bus outputs stay stable while stalled
  - m_cyc_o falls asynchronously on reset
  - req_ready_o=1 after reset

Source files
------------

// File: rtl/thor2022_hpt_inserter_pkg.sv
// rtl/thor2022_hpt_inserter_pkg.sv - HPT geometry, HPTE layout, insert FSM states and the shared PTG hash
package thor2022_hpt_inserter_pkg;

   localparam int AWID        = 32;
   localparam int PTE_PER_PTG = 8;
   localparam int HASH_BITS   = 10;
   localparam int HPTE_BYTES  = 16;
   localparam int PTG_BYTES   = PTE_PER_PTG * HPTE_BYTES;
   localparam int SLOT_W      = $clog2(PTE_PER_PTG);
   localparam int HPTE_SHIFT  = $clog2(HPTE_BYTES);
   localparam int PTG_SHIFT   = $clog2(PTG_BYTES);

   typedef struct packed {
      logic        v;
      logic [4:0]  rsvd;
      logic [9:0]  asid;
      logic [15:0] vpnhi;
      logic [31:0] vpn;
      logic [51:0] ppn;
      logic [11:0] attr;
   } hpte_t;

   typedef enum logic [2:0] {
      HPT_IDLE,
      HPT_RD,
      HPT_SEL,
      HPT_WR,
      HPT_FIN
   } hpt_state_e;

   // The table walker calls this too, so both sides land on the same PTG.
   function automatic logic [HASH_BITS-1:0] hpt_hash(input logic [9:0] asid, input logic [31:0] vpn);
      return vpn[HASH_BITS-1:0] ^ asid;
   endfunction

endpackage

// File: rtl/thor2022_hpt_inserter_if.sv
// rtl/thor2022_hpt_inserter_if.sv - insert request/completion and memory-bus signals of the HPT inserter
interface thor2022_hpt_inserter_if;
   import thor2022_hpt_inserter_pkg::*;

   logic            req_i;
   logic            req_ready_o;
   logic [127:0]    hpte_i;
   logic [AWID-1:0] hpt_base_i;
   logic            done_o;
   logic [2:0]      slot_o;
   logic            evict_o;
   logic            err_o;
   logic            m_cyc_o;
   logic            m_we_o;
   logic [AWID-1:0] m_adr_o;
   logic [127:0]    m_dat_o;
   logic [127:0]    m_dat_i;
   logic            m_ack_i;
   logic            m_err_i;

   modport master (
      input  req_i, hpte_i, hpt_base_i, m_dat_i, m_ack_i, m_err_i,
      output req_ready_o, done_o, slot_o, evict_o, err_o,
             m_cyc_o, m_we_o, m_adr_o, m_dat_o
   );

   modport slave (
      output req_i, hpte_i, hpt_base_i, m_dat_i, m_ack_i, m_err_i,
      input  req_ready_o, done_o, slot_o, evict_o, err_o,
             m_cyc_o, m_we_o, m_adr_o, m_dat_o
   );

endinterface

// File: rtl/thor2022_hpt_slot_sel.sv
// rtl/thor2022_hpt_slot_sel.sv - classifies a read-back HPTE and remembers the first free slot of the scan
module thor2022_hpt_slot_sel
   import thor2022_hpt_inserter_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              beat_i,
   input  logic [SLOT_W-1:0] k_i,
   input  hpte_t             dat_i,
   input  hpte_t             ent_i,
   output logic              match_o,
   output logic              free_found_o,
   output logic [SLOT_W-1:0] free_slot_o
);

   logic              free;
   logic              found_q, found_d;
   logic [SLOT_W-1:0] fslot_q, fslot_d;

   assign match_o = dat_i.v
                 && (dat_i.asid  == ent_i.asid)
                 && (dat_i.vpn   == ent_i.vpn)
                 && (dat_i.vpnhi == ent_i.vpnhi);
   assign free = !dat_i.v;

   always_comb begin
      found_d = found_q;
      fslot_d = fslot_q;
      if (clr_i) begin
         found_d = 1'b0;
         fslot_d = '0;
      end else if (beat_i && free && !found_q) begin
         found_d = 1'b1;
         fslot_d = k_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         found_q <= 1'b0;
         fslot_q <= '0;
      end else begin
         found_q <= found_d;
         fslot_q <= fslot_d;
      end
   end

   assign free_found_o = found_q;
   assign free_slot_o  = fslot_q;

endmodule

// File: rtl/thor2022_hpt_inserter.sv
// rtl/thor2022_hpt_inserter.sv - hash page table insert engine: scan one PTG, write match/free/victim slot
module thor2022_hpt_inserter
   import thor2022_hpt_inserter_pkg::*;
(
   input logic                     clk_i,
   input logic                     rst_ni,
   thor2022_hpt_inserter_if.master bus
);

   hpt_state_e        state_q, state_d;
   logic [SLOT_W-1:0] k_q, k_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [SLOT_W-1:0] clk_ptr_q, clk_ptr_d;
   hpte_t             ent_q, ent_d;
   logic [AWID-1:0]   base_q, base_d;
   logic              evict_q, evict_d;
   logic              err_q, err_d;

   logic              scan_clr;
   logic              rd_beat;
   logic              slot_match;
   logic              free_found;
   logic [SLOT_W-1:0] free_slot;
   logic [AWID-1:0]   ptg_adr;
   logic [AWID-1:0]   rd_adr;
   logic [AWID-1:0]   wr_adr;
   hpte_t             wr_ent;

   assign ptg_adr = base_q + (AWID'(hpt_hash(ent_q.asid, ent_q.vpn)) << PTG_SHIFT);
   assign rd_adr  = ptg_adr + (AWID'(k_q) << HPTE_SHIFT);
   assign wr_adr  = ptg_adr + (AWID'(slot_q) << HPTE_SHIFT);
   assign rd_beat = (state_q == HPT_RD) && bus.m_ack_i;

   always_comb begin
      wr_ent   = ent_q;
      wr_ent.v = 1'b1;
   end

   thor2022_hpt_slot_sel u_slot_sel (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_i        (scan_clr),
      .beat_i       (rd_beat),
      .k_i          (k_q),
      .dat_i        (hpte_t'(bus.m_dat_i)),
      .ent_i        (ent_q),
      .match_o      (slot_match),
      .free_found_o (free_found),
      .free_slot_o  (free_slot)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      slot_d    = slot_q;
      clk_ptr_d = clk_ptr_q;
      ent_d     = ent_q;
      base_d    = base_q;
      evict_d   = evict_q;
      err_d     = err_q;
      scan_clr  = 1'b0;
      case (state_q)
         HPT_IDLE: begin
            if (bus.req_i) begin
               ent_d    = hpte_t'(bus.hpte_i);
               base_d   = bus.hpt_base_i;
               k_d      = '0;
               evict_d  = 1'b0;
               err_d    = 1'b0;
               scan_clr = 1'b1;
               state_d  = HPT_RD;
            end
         end
         HPT_RD: begin
            if (bus.m_err_i) begin
               err_d   = 1'b1;
               state_d = HPT_FIN;
            end else if (bus.m_ack_i) begin
               // A match ends the scan at once, so it beats any earlier free slot.
               if (slot_match) begin
                  slot_d  = k_q;
                  state_d = HPT_WR;
               end else if (k_q == SLOT_W'(PTE_PER_PTG - 1)) begin
                  state_d = HPT_SEL;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         HPT_SEL: begin
            if (free_found) begin
               slot_d = free_slot;
            end else begin
               slot_d    = clk_ptr_q;
               evict_d   = 1'b1;
               clk_ptr_d = clk_ptr_q + 1'b1;
            end
            state_d = HPT_WR;
         end
         HPT_WR: begin
            if (bus.m_err_i) begin
               err_d   = 1'b1;
               evict_d = 1'b0;
               state_d = HPT_FIN;
            end else if (bus.m_ack_i) begin
               state_d = HPT_FIN;
            end
         end
         HPT_FIN: begin
            state_d = HPT_IDLE;
         end
         default: begin
            state_d = HPT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= HPT_IDLE;
         k_q       <= '0;
         slot_q    <= '0;
         clk_ptr_q <= '0;
         ent_q     <= '0;
         base_q    <= '0;
         evict_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         slot_q    <= slot_d;
         clk_ptr_q <= clk_ptr_d;
         ent_q     <= ent_d;
         base_q    <= base_d;
         evict_q   <= evict_d;
         err_q     <= err_d;
      end
   end

   // Bus outputs decode straight from the state flops, so an async reset drops the cycle instantly.
   assign bus.req_ready_o = (state_q == HPT_IDLE);
   assign bus.done_o      = (state_q == HPT_FIN);
   assign bus.slot_o      = (state_q == HPT_FIN) ? slot_q : '0;
   assign bus.evict_o     = (state_q == HPT_FIN) && evict_q;
   assign bus.err_o       = (state_q == HPT_FIN) && err_q;
   assign bus.m_cyc_o     = (state_q == HPT_RD) || (state_q == HPT_WR);
   assign bus.m_we_o      = (state_q == HPT_WR);
   assign bus.m_adr_o     = (state_q == HPT_RD) ? rd_adr :
                            (state_q == HPT_WR) ? wr_adr : '0;
   assign bus.m_dat_o     = (state_q == HPT_WR) ? wr_ent : '0;

endmodule
